fetch_stage: RTL and testbench

//  Instruction-fetch front end: owns the PC, issues in-order fetches to the I-cache,

---
 rtl/fetch_stage.sv | 131 +++++++++++++
 tb/tb_fetch_stage.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch front end: PC generation, in-order I-cache requests, response
// buffering with matching PCs, and the fetch/decode pipe register.
module fetch_stage #(
  parameter int unsigned          REG_WIDTH  = 32,
  parameter logic [REG_WIDTH-1:0] RESET_PC   = 'h0000_1000,
  parameter int unsigned          FIFO_DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   redirect_valid,
  input  logic [REG_WIDTH-1:0]   redirect_pc,
  input  logic                   stall_D,
  output logic                   icache_req_valid,
  output logic [REG_WIDTH-1:0]   icache_req_addr,
  input  logic                   icache_req_ready,
  input  logic                   icache_resp_valid,
  input  logic [REG_WIDTH-1:0]   icache_resp_data,
  output logic                   pipe_D_valid,
  output logic [2*REG_WIDTH-1:0] pipe_D_o
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef struct packed {
    logic [REG_WIDTH-1:0] instr;
    logic [REG_WIDTH-1:0] pc;
  } cable_pipe_D_t;

  localparam logic [REG_WIDTH-1:0] NOP    = REG_WIDTH'(32'h0000_0013);
  localparam cable_pipe_D_t        BUBBLE = '{instr: NOP, pc: '0};

  logic [REG_WIDTH-1:0] pc_q;
  logic [CNT_W-1:0]     inflight_q;
  logic [CNT_W-1:0]     drop_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [PTR_W-1:0]     fifo_wr_q, fifo_rd_q;
  logic [PTR_W-1:0]     pcq_wr_q, pcq_rd_q;
  cable_pipe_D_t        fifo_mem [FIFO_DEPTH];
  logic [REG_WIDTH-1:0] pcq_mem  [FIFO_DEPTH];
  cable_pipe_D_t        pipe_q;
  logic                 pipe_valid_q;

  logic [CNT_W:0]       occupancy;
  logic                 credit_ok;
  logic                 req_fire;
  logic                 resp_ok;
  logic                 resp_keep;
  logic                 fifo_pop;
  cable_pipe_D_t        resp_entry;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Credits cover both requests still in the cache and words waiting in the FIFO.
  always_comb begin
    occupancy        = {1'b0, inflight_q} + {1'b0, cnt_q};
    credit_ok        = occupancy < (CNT_W + 1)'(FIFO_DEPTH);
    icache_req_valid = !rst && !redirect_valid && credit_ok;
    req_fire         = icache_req_valid && icache_req_ready;
    resp_ok          = icache_resp_valid && (inflight_q != '0);
    resp_keep        = resp_ok && (drop_q == '0);
    fifo_pop         = !stall_D && (cnt_q != '0);
    resp_entry.instr = icache_resp_data;
    resp_entry.pc    = pcq_mem[pcq_rd_q];
  end

  assign icache_req_addr = pc_q;
  assign pipe_D_valid    = pipe_valid_q;
  assign pipe_D_o        = pipe_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q         <= RESET_PC;
      inflight_q   <= '0;
      drop_q       <= '0;
      cnt_q        <= '0;
      fifo_wr_q    <= '0;
      fifo_rd_q    <= '0;
      pcq_wr_q     <= '0;
      pcq_rd_q     <= '0;
      pipe_q       <= BUBBLE;
      pipe_valid_q <= 1'b0;
    end else if (redirect_valid) begin
      // Every request still in the cache is now wrong-path and must be discarded.
      pc_q         <= redirect_pc & ~REG_WIDTH'(3);
      inflight_q   <= inflight_q - CNT_W'(resp_ok);
      drop_q       <= inflight_q - CNT_W'(resp_ok);
      cnt_q        <= '0;
      fifo_wr_q    <= '0;
      fifo_rd_q    <= '0;
      pcq_wr_q     <= '0;
      pcq_rd_q     <= '0;
      pipe_q       <= BUBBLE;
      pipe_valid_q <= 1'b0;
    end else begin
      if (req_fire) begin
        pc_q              <= pc_q + REG_WIDTH'(4);
        pcq_mem[pcq_wr_q] <= pc_q;
        pcq_wr_q          <= ptr_inc(pcq_wr_q);
      end
      inflight_q <= inflight_q + CNT_W'(req_fire) - CNT_W'(resp_ok);
      if (resp_ok && (drop_q != '0)) begin
        drop_q <= drop_q - CNT_W'(1);
      end
      if (resp_keep) begin
        fifo_mem[fifo_wr_q] <= resp_entry;
        fifo_wr_q           <= ptr_inc(fifo_wr_q);
        pcq_rd_q            <= ptr_inc(pcq_rd_q);
      end
      cnt_q <= cnt_q + CNT_W'(resp_keep) - CNT_W'(fifo_pop);
      // Pipe register reads only buffered words; no same-cycle bypass from the cache.
      if (!stall_D) begin
        if (cnt_q != '0) begin
          pipe_q       <= fifo_mem[fifo_rd_q];
          pipe_valid_q <= 1'b1;
          fifo_rd_q    <= ptr_inc(fifo_rd_q);
        end else begin
          pipe_q       <= BUBBLE;
          pipe_valid_q <= 1'b0;
        end
      end
    end
  end

  resp_without_request: assert property (@(posedge clk) disable iff (rst)
    icache_resp_valid |-> (inflight_q != '0))
    else $error("icache response with no request in flight");

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage with a 1-cycle cache model that can be
// switched to manually driven responses.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        stall_D = 1'b0;
  logic        icache_req_valid;
  logic [31:0] icache_req_addr;
  logic        icache_req_ready = 1'b1;
  logic        icache_resp_valid;
  logic [31:0] icache_resp_data;
  logic        pipe_D_valid;
  logic [63:0] pipe_D_o;

  logic        auto_resp = 1'b1;
  logic        auto_valid = 1'b0;
  logic [31:0] auto_data = 32'h0;
  logic        man_valid = 1'b0;
  logic [31:0] man_data = 32'h0;
  logic [63:0] consumed [$];
  int          n_cmp = 0;
  int          n_err = 0;

  localparam logic [63:0] BUBBLE = {32'h0000_0013, 32'h0};

  fetch_stage dut (
    .clk               (clk),
    .rst               (rst),
    .redirect_valid    (redirect_valid),
    .redirect_pc       (redirect_pc),
    .stall_D           (stall_D),
    .icache_req_valid  (icache_req_valid),
    .icache_req_addr   (icache_req_addr),
    .icache_req_ready  (icache_req_ready),
    .icache_resp_valid (icache_resp_valid),
    .icache_resp_data  (icache_resp_data),
    .pipe_D_valid      (pipe_D_valid),
    .pipe_D_o          (pipe_D_o)
  );

  always #5 clk = ~clk;

  // Cache returns ~addr one cycle after each accepted request.
  assign icache_resp_valid = auto_resp ? auto_valid : man_valid;
  assign icache_resp_data  = auto_resp ? auto_data : man_data;
  always @(posedge clk) begin
    auto_valid <= icache_req_valid && icache_req_ready;
    auto_data  <= ~icache_req_addr;
  end

  // Decode consumes the pipe register on every unstalled edge.
  always @(posedge clk) begin
    if (rst === 1'b0 && stall_D === 1'b0 && pipe_D_valid === 1'b1) consumed.push_back(pipe_D_o);
  end

  function automatic logic [63:0] word_at(input logic [31:0] pc);
    return {~pc, pc};
  endfunction

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic drain();
    icache_req_ready = 1'b0;
    auto_resp        = 1'b1;
    tick(4);
    auto_resp = 1'b0;
    man_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(2);
    n_cmp++; if (icache_req_valid !== 1'b0) begin n_err++; $display("FAIL reset_req_valid got %b want 0", icache_req_valid); end
    n_cmp++; if (icache_req_addr !== 32'h1000) begin n_err++; $display("FAIL reset_req_addr got %h want 00001000", icache_req_addr); end
    n_cmp++; if (pipe_D_valid !== 1'b0) begin n_err++; $display("FAIL reset_pipe_valid got %b want 0", pipe_D_valid); end
    n_cmp++; if (pipe_D_o !== BUBBLE) begin n_err++; $display("FAIL reset_pipe_o got %h want %h", pipe_D_o, BUBBLE); end
  endtask

  task automatic test_stream();
    consumed.delete();
    rst = 1'b0;
    tick(1);
    n_cmp++; if (pipe_D_valid !== 1'b0) begin n_err++; $display("FAIL stream_early_valid got %b want 0", pipe_D_valid); end
    n_cmp++; if (icache_req_addr !== 32'h1004) begin n_err++; $display("FAIL stream_addr got %h want 00001004", icache_req_addr); end
    tick(2);
    n_cmp++; if (pipe_D_valid !== 1'b1) begin n_err++; $display("FAIL stream_first_valid got %b want 1", pipe_D_valid); end
    n_cmp++; if (pipe_D_o !== word_at(32'h1000)) begin n_err++; $display("FAIL stream_first_word got %h want %h", pipe_D_o, word_at(32'h1000)); end
    for (int k = 0; k < 40 && consumed.size() < 4; k++) tick();
    n_cmp++; if (consumed.size() < 4) begin n_err++; $display("FAIL stream_timeout got %0d words want 4", consumed.size()); end
    for (int i = 0; i < 4 && i < consumed.size(); i++) begin
      n_cmp++;
      if (consumed[i] !== word_at(32'h1000 + 32'(4 * i))) begin
        n_err++; $display("FAIL stream_word%0d got %h want %h", i, consumed[i], word_at(32'h1000 + 32'(4 * i)));
      end
    end
  endtask

  task automatic test_stall();
    logic [31:0] exp_pc;
    int          base;
    for (int k = 0; k < 10 && pipe_D_valid !== 1'b1; k++) tick();
    exp_pc  = 32'h1000 + 32'(4 * consumed.size());
    stall_D = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      n_cmp++; if (pipe_D_o !== word_at(exp_pc) || pipe_D_valid !== 1'b1) begin
        n_err++; $display("FAIL stall_hold%0d got %b/%h want 1/%h", c, pipe_D_valid, pipe_D_o, word_at(exp_pc));
      end
    end
    n_cmp++; if (icache_req_valid !== 1'b0) begin n_err++; $display("FAIL stall_credit got %b want 0", icache_req_valid); end
    stall_D = 1'b0;
    base = consumed.size();
    for (int k = 0; k < 40 && consumed.size() < base + 4; k++) tick();
    n_cmp++; if (consumed.size() < base + 4) begin n_err++; $display("FAIL stall_timeout got %0d words want %0d", consumed.size(), base + 4); end
    for (int i = 0; i < consumed.size(); i++) begin
      n_cmp++;
      if (consumed[i] !== word_at(32'h1000 + 32'(4 * i))) begin
        n_err++; $display("FAIL stall_seq%0d got %h want %h", i, consumed[i], word_at(32'h1000 + 32'(4 * i)));
      end
    end
  endtask

  task automatic test_redirect_inflight();
    drain();
    redirect_valid = 1'b1; redirect_pc = 32'h1000;
    tick();
    redirect_valid = 1'b0; icache_req_ready = 1'b1;
    consumed.delete();
    tick(2);
    n_cmp++; if (icache_req_valid !== 1'b0 || icache_req_addr !== 32'h1008) begin
      n_err++; $display("FAIL inflight_two got %b/%h want 0/00001008", icache_req_valid, icache_req_addr);
    end
    redirect_valid = 1'b1; redirect_pc = 32'h2000;
    #1;
    n_cmp++; if (icache_req_valid !== 1'b0) begin n_err++; $display("FAIL redirect_no_req got %b want 0", icache_req_valid); end
    tick();
    redirect_valid = 1'b0; man_valid = 1'b1; man_data = 32'hDEAD_0001;
    tick();
    n_cmp++; if (icache_req_valid !== 1'b1 || icache_req_addr !== 32'h2000) begin
      n_err++; $display("FAIL redirect_addr got %b/%h want 1/00002000", icache_req_valid, icache_req_addr);
    end
    man_data = 32'hDEAD_0002;
    tick();
    man_valid = 1'b0; auto_resp = 1'b1;
    n_cmp++; if (pipe_D_valid !== 1'b0) begin n_err++; $display("FAIL drop1_leak got %b want 0", pipe_D_valid); end
    tick();
    n_cmp++; if (pipe_D_valid !== 1'b0) begin n_err++; $display("FAIL drop2_leak got %b want 0", pipe_D_valid); end
    tick();
    n_cmp++; if (pipe_D_valid !== 1'b1 || pipe_D_o !== word_at(32'h2000)) begin
      n_err++; $display("FAIL redirect_target got %b/%h want 1/%h", pipe_D_valid, pipe_D_o, word_at(32'h2000));
    end
    n_cmp++; if (consumed.size() != 0) begin n_err++; $display("FAIL redirect_stale got %0d consumed want 0", consumed.size()); end
  endtask

  task automatic test_redirect_stall();
    drain();
    redirect_valid = 1'b1; redirect_pc = 32'h3000;
    tick();
    redirect_valid = 1'b0; icache_req_ready = 1'b1;
    tick(2);
    redirect_valid = 1'b1; redirect_pc = 32'h4000; stall_D = 1'b1;
    man_valid = 1'b1; man_data = 32'hDEAD_0003;
    tick();
    n_cmp++; if (pipe_D_valid !== 1'b0 || pipe_D_o !== BUBBLE) begin
      n_err++; $display("FAIL rs_bubble got %b/%h want 0/%h", pipe_D_valid, pipe_D_o, BUBBLE);
    end
    redirect_valid = 1'b0; stall_D = 1'b0; man_valid = 1'b0;
    #1;
    n_cmp++; if (icache_req_valid !== 1'b1 || icache_req_addr !== 32'h4000) begin
      n_err++; $display("FAIL rs_credit got %b/%h want 1/00004000", icache_req_valid, icache_req_addr);
    end
    tick();
    man_valid = 1'b1; man_data = 32'hDEAD_0004;
    tick();
    man_data = ~32'h4000;
    tick();
    man_data = ~32'h4004;
    tick();
    man_valid = 1'b0; icache_req_ready = 1'b0;
    n_cmp++; if (pipe_D_valid !== 1'b1 || pipe_D_o !== word_at(32'h4000)) begin
      n_err++; $display("FAIL rs_target got %b/%h want 1/%h", pipe_D_valid, pipe_D_o, word_at(32'h4000));
    end
  endtask

  task automatic test_ready_low();
    auto_resp = 1'b1;
    tick(2);
    for (int c = 0; c < 5; c++) begin
      tick();
      n_cmp++; if (icache_req_valid !== 1'b1 || icache_req_addr !== 32'h4008 || pipe_D_valid !== 1'b0) begin
        n_err++; $display("FAIL ready_low%0d got %b/%h/%b want 1/00004008/0", c, icache_req_valid, icache_req_addr, pipe_D_valid);
      end
    end
    consumed.delete();
    icache_req_ready = 1'b1;
    for (int k = 0; k < 20 && consumed.size() < 1; k++) tick();
    n_cmp++; if (consumed.size() < 1 || consumed[0] !== word_at(32'h4008)) begin
      n_err++; $display("FAIL ready_resume got %0d/%h want 1/%h", consumed.size(), (consumed.size() > 0) ? consumed[0] : 64'h0, word_at(32'h4008));
    end
  endtask

  task automatic test_wrap();
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFE;
    tick();
    redirect_valid = 1'b0;
    consumed.delete();
    n_cmp++; if (icache_req_addr !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_align got %h want fffffffc", icache_req_addr); end
    for (int k = 0; k < 30 && consumed.size() < 2; k++) tick();
    n_cmp++; if (consumed.size() < 2) begin n_err++; $display("FAIL wrap_timeout got %0d words want 2", consumed.size()); end
    if (consumed.size() >= 2) begin
      n_cmp++; if (consumed[0] !== word_at(32'hFFFF_FFFC)) begin n_err++; $display("FAIL wrap_first got %h want %h", consumed[0], word_at(32'hFFFF_FFFC)); end
      n_cmp++; if (consumed[1] !== word_at(32'h0)) begin n_err++; $display("FAIL wrap_second got %h want %h", consumed[1], word_at(32'h0)); end
    end
  endtask

  task automatic test_reset_mid();
    rst = 1'b1;
    #1;
    n_cmp++; if (icache_req_valid !== 1'b0) begin n_err++; $display("FAIL rmid_req got %b want 0", icache_req_valid); end
    tick();
    n_cmp++; if (pipe_D_valid !== 1'b0 || icache_req_addr !== 32'h1000) begin
      n_err++; $display("FAIL rmid_state got %b/%h want 0/00001000", pipe_D_valid, icache_req_addr);
    end
    rst = 1'b0;
    consumed.delete();
    for (int k = 0; k < 20 && consumed.size() < 1; k++) tick();
    n_cmp++; if (consumed.size() < 1 || consumed[0] !== word_at(32'h1000)) begin
      n_err++; $display("FAIL rmid_restart got %0d/%h want 1/%h", consumed.size(), (consumed.size() > 0) ? consumed[0] : 64'h0, word_at(32'h1000));
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect_inflight();
    test_redirect_stall();
    test_ready_low();
    test_wrap();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
